// File: rtl/updown_seq_driver.sv
// updown_seq_driver
//   Drives the direction bit of a W-bit up/down counter (0 = up, 1 = down),
//   keeps a cycle-exact mirror of the counter state, and steers the counter
//   to a requested target along the shortest modular path. When the target
//   is reached, done pulses for one cycle.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request strobe, accepted only while ready = 1
//   target     : requested counter state, latched on an accepted start
//   ready      : 1 = idle and able to accept start
//   A          : registered direction bit to the counter
//   cnt_mirror : registered model of the counter state
//   Y          : expected counter Y output (all-ones detect of the mirror)
//   done       : one-cycle pulse when the mirror reaches the latched target
//   steps      : edges taken by the last/current request, saturating
module updown_seq_driver #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] target,
  output logic         ready,
  output logic         A,
  output logic [W-1:0] cnt_mirror,
  output logic         Y,
  output logic         done,
  output logic [W:0]   steps
);

  typedef enum logic {
    IDLE,
    SEEK
  } state_t;

  localparam logic [W:0] MODULUS = (W+1)'(2 ** W);

  state_t       state, state_nx;
  logic [W-1:0] tgt, tgt_nx;
  logic [W-1:0] mirror_nx;
  logic [W-1:0] goal;
  logic [W-1:0] d_up;
  logic [W:0]   d_dn;
  logic         go_down;
  logic         a_nx, ready_nx, done_nx;
  logic [W:0]   steps_nx;

  assign Y = &cnt_mirror;

  // Mirror follows the counter using the direction bit present before the edge.
  assign mirror_nx = A ? cnt_mirror - W'(1) : cnt_mirror + W'(1);

  // In IDLE the target being latched on this edge is the live input.
  assign goal    = (state == IDLE) ? target : tgt;
  assign d_up    = goal - mirror_nx;
  assign d_dn    = MODULUS - {1'b0, d_up};
  // Strict compare: a tie resolves to counting up.
  assign go_down = d_dn < {1'b0, d_up};

  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    a_nx     = 1'b0;
    ready_nx = ready;
    done_nx  = 1'b0;
    steps_nx = steps;
    unique case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (start) begin
          tgt_nx   = target;
          steps_nx = (W+1)'(1);
          if (mirror_nx == target) begin
            done_nx = 1'b1;
          end else begin
            ready_nx = 1'b0;
            state_nx = SEEK;
            a_nx     = go_down;
          end
        end
      end
      SEEK: begin
        steps_nx = (&steps) ? steps : steps + (W+1)'(1);
        if (mirror_nx == tgt) begin
          done_nx  = 1'b1;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          a_nx = go_down;
        end
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tgt        <= '0;
      A          <= 1'b0;
      cnt_mirror <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
      steps      <= '0;
    end else begin
      state      <= state_nx;
      tgt        <= tgt_nx;
      A          <= a_nx;
      cnt_mirror <= mirror_nx;
      ready      <= ready_nx;
      done       <= done_nx;
      steps      <= steps_nx;
    end
  end

endmodule
